// File: rtl/lsu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu: byte/half/word load-store unit; misaligned accesses span two memory words
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int MASK_SIZE = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_write_en,
  output logic [MASK_SIZE-1:0]  mem_mask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   part_q, part_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [1:0]              off;
  logic [2:0]              nbytes;
  logic [MASK_SIZE-1:0]    nmask;
  logic                    split;
  logic [2*MASK_SIZE-1:0]  span;
  logic [4:0]              lo_sh;
  logic [5:0]              hi_sh;
  logic [2*DATA_WIDTH-1:0] wshift;
  logic [ADDR_WIDTH-1:0]   base;
  logic [DATA_WIDTH-1:0]   gathered;

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                   input logic [1:0] sz,
                                                   input logic uns);
    logic [DATA_WIDTH-1:0] r;
    case (sz)
      2'b00:   r = {{(DATA_WIDTH-8){~uns & v[7]}}, v[7:0]};
      2'b01:   r = {{(DATA_WIDTH-16){~uns & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    nbytes = 3'd4;
    nmask  = {MASK_SIZE{1'b1}};
    case (size_q)
      2'b00: begin nbytes = 3'd1; nmask = MASK_SIZE'(1); end
      2'b01: begin nbytes = 3'd2; nmask = MASK_SIZE'(3); end
      default: ;
    endcase
  end

  assign off    = addr_q[1:0];
  assign split  = ({1'b0, off} + nbytes) > 3'd4;
  // Both lane masks and store data are built in a double-width window: the
  // low half feeds the first word, the overflow feeds the second.
  assign span   = {{MASK_SIZE{1'b0}}, nmask} << off;
  assign lo_sh  = {off, 3'b000};
  assign hi_sh  = 6'd32 - {1'b0, lo_sh};
  assign wshift = {{DATA_WIDTH{1'b0}}, wdata_q} << lo_sh;
  assign base   = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    part_d       = part_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    gathered     = '0;
    mem_write_en = 1'b0;
    mem_mask     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          part_d  = '0;
          state_d = ACC0;
        end
      end
      ACC0: begin
        mem_addr = base;
        if (we_q) begin
          mem_write_en = 1'b1;
          mem_mask     = span[MASK_SIZE-1:0];
          mem_wdata    = wshift[DATA_WIDTH-1:0];
        end
        gathered = mem_rdata >> lo_sh;
        part_d   = gathered;
        if (split) begin
          state_d = ACC1;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : extend(gathered, size_q, uns_q);
        end
      end
      ACC1: begin
        mem_addr = base + ADDR_WIDTH'(4);
        if (we_q) begin
          mem_write_en = 1'b1;
          mem_mask     = span[2*MASK_SIZE-1:MASK_SIZE];
          mem_wdata    = wshift[2*DATA_WIDTH-1:DATA_WIDTH];
        end
        gathered    = part_q | (mem_rdata << hi_sh);
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? '0 : extend(gathered, size_q, uns_q);
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      part_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      part_q      <= part_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data path width (only 32 supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width; local MASK_SIZE = DATA_WIDTH/8.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; arst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have req_valid  input  1  core request present.
REQ-005 SHALL have req_ready  output  1  LSU can accept a request.
REQ-006 SHALL have req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have req_unsigned  input  1  zero-extend load result (LBU/LHU).
REQ-009 SHALL have req_addr  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have req_wdata  input  DATA_WIDTH  store data, right-justified.
REQ-011 SHALL have rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores.
REQ-013 SHALL have mem_write_en, mem_mask[MASK_SIZE], mem_addr[ADDR_WIDTH], mem_wdata[DATA_WIDTH] outputs and mem_rdata[DATA_WIDTH] input, connecting to the shared memory (combinational read, write on clk rising edge).

Function
REQ-014 SHALL implement FSM IDLE -> ACC0 -> (ACC1) -> RESP -> IDLE.
REQ-015 SHALL assert req_ready only in IDLE; accept on req_valid && req_ready and register all req_* fields.
REQ-016 SHALL, with off = addr[1:0] and n = 1/2/4 bytes, use ACC1 only when off + n > 4 (split access).
REQ-017 SHALL in ACC0 drive mem_addr = {addr[31:2], 2'b00}; stores: mem_write_en = 1, mem_mask = lanes off..min(off+n-1, 3), mem_wdata = req_wdata << 8*off.
REQ-018 SHALL in ACC1 drive mem_addr = {addr[31:2], 2'b00} + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0); stores: mask = lanes 0..off+n-5, mem_wdata = req_wdata >> 8*(4-off).
REQ-019 SHALL, for loads, keep mem_write_en = 0 and mem_mask = 0, capture mem_rdata lanes off..3 in ACC0 into result bytes 0.., and lanes 0..off+n-5 in ACC1 into the following result bytes.
REQ-020 SHALL in RESP assert rsp_valid for exactly one cycle, with rsp_rdata sign-extended from bit 8n-1 unless req_unsigned = 1 (zero-extended); for words, req_unsigned is ignored.
REQ-021 SHALL drive all mem_* outputs to 0 in IDLE and RESP.
REQ-022 SHALL give latency accept at edge T: aligned access -> rsp_valid in cycle T+2; split access -> rsp_valid in cycle T+3; next accept no earlier than the cycle after RESP.
REQ-023 SHALL ignore req_* changes while not in IDLE; rsp_valid does not wait for a ready signal.

Reset
REQ-024 SHALL, on arst_n low, immediately (asynchronously) force state IDLE, rsp_valid = 0, rsp_rdata = 0, mem_write_en = 0, mem_mask = 0, mem_addr = 0, mem_wdata = 0, req_ready = 1, clear the captured request, and issue no response for an aborted access.
REQ-025 SHALL leave memory contents written in a completed ACC0 unchanged when reset is asserted mid-split-store (no rollback).

Verification
REQ-026 SHALL cover: SW 0xDEADBEEF @0x100 -> ACC0: write_en = 1, mask = 1111, addr = 0x100, wdata = 0xDEADBEEF; rsp_valid at T+2, rdata = 0.
REQ-027 SHALL cover: SB 0x000000A5 @0x103 -> mask = 1000, wdata = 0xA5000000, addr = 0x100; single memory cycle.
REQ-028 SHALL cover: LH @0x102 with mem_rdata = 0x8001_1234 -> rdata = 0xFFFF8001; LHU -> 0x00008001; mem_write_en stays 0.
REQ-029 SHALL cover: LW @0x0FE, ACC0 addr 0xFC with rdata 0x3344_0000, ACC1 addr 0x100 with rdata 0x0000_1122 -> rsp_rdata = 0x11223344 at T+3.
REQ-030 SHALL cover: SW 0xAABBCCDD @0x101 -> ACC0 addr 0x100, mask 1110, wdata 0xBBCCDD00; ACC1 addr 0x104, mask 0001, wdata 0x000000AA.
REQ-031 SHALL cover: arst_n low during ACC1 of split store -> all mem_* outputs 0 at once, no rsp_valid; after release req_ready = 1 and the next SW @0xFFFF_FFFE splits with ACC1 addr 0x0.
